// File: rtl/cnn_input_loader.sv
// Front-end write controller for the convolution core: streams weight bytes into
// the weight RAM and 8x8 frames into a two-bank ping-pong data buffer.
module cnn_input_loader #(
  parameter int W_BYTES = 54,
  parameter int D_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [7:0] din,
  input  logic       ram_en,
  input  logic       frame_release,
  output logic       w_we,
  output logic [5:0] w_addr,
  output logic [7:0] w_data,
  output logic       d_we,
  output logic       d_bank,
  output logic [5:0] d_addr,
  output logic [7:0] d_data,
  output logic       weights_ok,
  output logic       frame_avail,
  output logic       frame_bank,
  output logic [7:0] frame_cnt,
  output logic       overflow
);

  localparam logic [5:0] W_LAST = 6'(W_BYTES - 1);
  localparam logic [5:0] D_LAST = 6'(D_BYTES - 1);

  logic [5:0] w_cnt;
  logic [5:0] d_cnt;
  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;

  logic       w_acc;
  logic       d_req;
  logic       d_acc;
  logic       d_last;
  logic       rel_ok;
  logic [1:0] full_set;
  logic [1:0] full_clr;

  // The full check sees only registered flags, so a release never frees a bank
  // for a byte arriving in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns each signal; otherwise latches are inferred.
    full_set = '0;
    full_clr = '0;
    w_acc    = ram_en & mode;
    d_req    = ram_en & ~mode;
    d_acc    = d_req & ~full[wr_bank];
    d_last   = d_acc & (d_cnt == D_LAST);
    rel_ok   = frame_release & full[rd_bank];
    if (d_last) full_set[wr_bank] = 1'b1;
    if (rel_ok) full_clr[rd_bank] = 1'b1;
  end

  assign frame_bank = rd_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_we        <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      d_we        <= 1'b0;
      d_bank      <= 1'b0;
      d_addr      <= '0;
      d_data      <= '0;
      weights_ok  <= 1'b0;
      frame_avail <= 1'b0;
      frame_cnt   <= '0;
      overflow    <= 1'b0;
      w_cnt       <= '0;
      d_cnt       <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
      w_we <= w_acc;
      d_we <= d_acc;

      if (w_acc) begin
        w_addr <= w_cnt;
        w_data <= din;
        if (w_cnt == W_LAST) begin
          w_cnt      <= '0;
          weights_ok <= 1'b1;
        end else begin
          w_cnt <= w_cnt + 6'd1;
          if (w_cnt == '0) weights_ok <= 1'b0;
        end
        // A weight byte abandons any partially written frame.
        d_cnt <= '0;
      end

      if (d_req && full[wr_bank]) overflow <= 1'b1;

      if (d_acc) begin
        d_bank <= wr_bank;
        d_addr <= d_cnt;
        d_data <= din;
        if (d_last) begin
          d_cnt     <= '0;
          wr_bank   <= ~wr_bank;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          d_cnt <= d_cnt + 6'd1;
        end
      end

      if (rel_ok) rd_bank <= ~rd_bank;
      full <= (full & ~full_clr) | full_set;

      // Built from registered state so it trails the frame's last write strobe by a cycle.
      frame_avail <= full[rd_bank] & weights_ok;
    end
  end

endmodule

// File: tb/tb_cnn_input_loader.sv
// Self-checking bench for cnn_input_loader: directed phases with random byte
// values, compared cycle by cycle against a counter/flag reference model.
module tb_cnn_input_loader;

  localparam int W_BYTES = 54;
  localparam int D_BYTES = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] din = '0;
  logic       ram_en = 1'b0;
  logic       frame_release = 1'b0;
  logic       w_we;
  logic [5:0] w_addr;
  logic [7:0] w_data;
  logic       d_we;
  logic       d_bank;
  logic [5:0] d_addr;
  logic [7:0] d_data;
  logic       weights_ok;
  logic       frame_avail;
  logic       frame_bank;
  logic [7:0] frame_cnt;
  logic       overflow;

  cnn_input_loader #(.W_BYTES(W_BYTES), .D_BYTES(D_BYTES)) dut (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .ram_en(ram_en),
    .frame_release(frame_release),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .d_we(d_we), .d_bank(d_bank), .d_addr(d_addr), .d_data(d_data),
    .weights_ok(weights_ok), .frame_avail(frame_avail), .frame_bank(frame_bank),
    .frame_cnt(frame_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: byte counts and per-bank occupancy.
  int m_w, m_d, m_frames;
  bit m_full [2];
  bit m_wb, m_rd, m_wok, m_ovf, m_avail, m_avail_d;

  // Strobe tallies taken from the DUT, compared against expected totals.
  int cnt_dwe, cnt_wwe, cnt_b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_d = 0; m_frames = 0;
    m_full[0] = 0; m_full[1] = 0;
    m_wb = 0; m_rd = 0; m_wok = 0; m_ovf = 0; m_avail = 0; m_avail_d = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".w_we"}, 32'(w_we), 0);
    check({tag, ".w_addr"}, 32'(w_addr), 0);
    check({tag, ".w_data"}, 32'(w_data), 0);
    check({tag, ".d_we"}, 32'(d_we), 0);
    check({tag, ".d_bank"}, 32'(d_bank), 0);
    check({tag, ".d_addr"}, 32'(d_addr), 0);
    check({tag, ".d_data"}, 32'(d_data), 0);
    check({tag, ".weights_ok"}, 32'(weights_ok), 0);
    check({tag, ".frame_avail"}, 32'(frame_avail), 0);
    check({tag, ".frame_bank"}, 32'(frame_bank), 0);
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, ".overflow"}, 32'(overflow), 0);
  endtask

  // One clock: drive inputs at the falling edge, predict, check #1 after the rising edge.
  task automatic cycle(input bit en, input bit md, input logic [7:0] b, input bit rel);
    bit e_wwe, e_dwe, e_dbank, e_avail, rel_ok;
    int e_waddr, e_daddr;
    ram_en = en; mode = md; din = b; frame_release = rel;
    e_wwe = 0; e_dwe = 0; e_dbank = 0; e_waddr = 0; e_daddr = 0;
    e_avail = m_full[m_rd] && m_wok;
    rel_ok  = rel && m_full[m_rd];
    if (en && md) begin
      e_wwe = 1; e_waddr = m_w;
      if (m_w == W_BYTES - 1) begin m_w = 0; m_wok = 1; end
      else begin if (m_w == 0) m_wok = 0; m_w++; end
      m_d = 0;
    end else if (en) begin
      if (m_full[m_wb]) m_ovf = 1;
      else begin
        e_dwe = 1; e_dbank = m_wb; e_daddr = m_d;
        if (m_d == D_BYTES - 1) begin
          m_full[m_wb] = 1; m_wb = ~m_wb; m_d = 0; m_frames = (m_frames + 1) % 256;
        end else m_d++;
      end
    end
    if (rel_ok) begin m_full[m_rd] = 0; m_rd = ~m_rd; end
    @(posedge clk); #1;
    check("w_we", 32'(w_we), 32'(e_wwe));
    if (e_wwe) begin
      check("w_addr", 32'(w_addr), e_waddr);
      check("w_data", 32'(w_data), 32'(b));
    end
    check("d_we", 32'(d_we), 32'(e_dwe));
    if (e_dwe) begin
      check("d_bank", 32'(d_bank), 32'(e_dbank));
      check("d_addr", 32'(d_addr), e_daddr);
      check("d_data", 32'(d_data), 32'(b));
    end
    check("weights_ok", 32'(weights_ok), 32'(m_wok));
    check("frame_avail", 32'(frame_avail), 32'(e_avail));
    check("frame_bank", 32'(frame_bank), 32'(m_rd));
    check("frame_cnt", 32'(frame_cnt), m_frames);
    check("overflow", 32'(overflow), 32'(m_ovf));
    m_avail_d = m_avail; m_avail = e_avail;
    if (d_we) begin cnt_dwe++; if (d_bank == 1'b0) cnt_b0++; end
    if (w_we) cnt_wwe++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit auto_rel);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, auto_rel && m_avail && !m_avail_d);
  endtask

  task automatic load_weights_random();
    int sent = 0;
    while (sent < W_BYTES) begin
      if ($urandom_range(3) != 0) begin cycle(1, 1, 8'($urandom), 0); sent++; end
      else cycle(0, 0, 8'($urandom), 0);
    end
  endtask

  task automatic data_bytes(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 8'($urandom), 0);
  endtask

  task automatic quiet_reset();
    ram_en = 0; frame_release = 0; rst = 1;
    @(posedge clk); #1;
    check_all_zero("rst_idle");
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 0;

    // Weight load 0..53.
    cnt_wwe = 0;
    for (int i = 0; i < W_BYTES; i++) cycle(1, 1, 8'(i), 0);
    check("wload.count", cnt_wwe, W_BYTES);
    check("wload.ok", 32'(weights_ok), 1);
    idle(2, 0);
    check("wload.ok_hold", 32'(weights_ok), 1);

    // First frame into bank 0.
    cnt_dwe = 0; cnt_b0 = 0;
    data_bytes(D_BYTES);
    check("f1.avail_before", 32'(frame_avail), 0);
    idle(1, 0);
    check("f1.avail", 32'(frame_avail), 1);
    check("f1.bank", 32'(frame_bank), 0);
    check("f1.cnt", 32'(frame_cnt), 1);
    check("f1.b0_writes", cnt_b0, D_BYTES);

    // Bank 1 fills, third frame is dropped entirely.
    data_bytes(D_BYTES);
    check("f2.cnt", 32'(frame_cnt), 2);
    cnt_dwe = 0;
    data_bytes(D_BYTES);
    check("f3.no_we", cnt_dwe, 0);
    check("f3.overflow", 32'(overflow), 1);
    check("f3.cnt", 32'(frame_cnt), 2);

    // Release and byte to the same full bank in one cycle: byte dropped.
    cnt_dwe = 0;
    cycle(1, 0, 8'h5a, 1);
    check("samecyc.drop", cnt_dwe, 0);
    cycle(1, 0, 8'ha5, 0);
    check("samecyc.next_we", 32'(d_we), 1);
    check("samecyc.next_addr", 32'(d_addr), 0);
    check("samecyc.next_bank", 32'(d_bank), 0);

    // 100 back-to-back frames with prompt releases.
    quiet_reset();
    load_weights_random();
    cnt_dwe = 0; cnt_b0 = 0;
    for (int i = 0; i < 100 * D_BYTES; i++)
      cycle(1, 0, 8'($urandom), m_avail && !m_avail_d);
    idle(4, 1);
    check("stream.cnt", 32'(frame_cnt), 100);
    check("stream.overflow", 32'(overflow), 0);
    check("stream.writes", cnt_dwe, 100 * D_BYTES);
    check("stream.bank0", cnt_b0, 50 * D_BYTES);

    // Partial frame discarded by a weight byte.
    data_bytes(30);
    cycle(1, 1, 8'h77, 0);
    cycle(1, 0, 8'h3c, 0);
    check("partial.addr", 32'(d_addr), 0);
    check("partial.bank", 32'(d_bank), 0);
    idle(3, 0);
    check("partial.no_avail", 32'(frame_avail), 0);

    // Finish the weight set, then reset asynchronously at data byte 40.
    for (int i = 1; i < W_BYTES; i++) cycle(1, 1, 8'($urandom), 0);
    data_bytes(39);
    ram_en = 1; mode = 0; din = 8'hee;
    #2 rst = 1;
    #1 check_all_zero("async_rst");
    @(posedge clk); #1;
    check("async_rst.no_wwe", 32'(w_we), 0);
    check("async_rst.no_dwe", 32'(d_we), 0);
    @(negedge clk);
    rst = 0; ram_en = 0;
    model_reset();

    cycle(1, 0, 8'h11, 0);
    check("post_rst.addr", 32'(d_addr), 0);
    check("post_rst.bank", 32'(d_bank), 0);
    data_bytes(D_BYTES - 1);
    idle(2, 0);
    check("post_rst.no_avail", 32'(frame_avail), 0);
    check("post_rst.ok", 32'(weights_ok), 0);
    check("post_rst.cnt", 32'(frame_cnt), 1);
    load_weights_random();
    idle(2, 0);
    check("post_rst.avail", 32'(frame_avail), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_input_loader.md
# cnn_input_loader

Front-end write controller that sits directly upstream of the convolution core. It accepts the serial byte stream (`din`, `mode`, `ram_en`) and writes the 54 weight bytes into the weight RAM. Successive 8x8 image frames go into a two-bank ping-pong data buffer, and the loader tells the core when a complete frame is ready. Frames can arrive back-to-back with `ram_en` held high, so loading of frame N+1 overlaps computation on frame N.

## Interface
- `W_BYTES`, default 54: weight bytes per load (3x3x3x2).
- `D_BYTES`, default 64: data bytes per frame (8x8x1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 1: 1 = weight byte, 0 = data byte; sampled with `ram_en`.
- `din` in 8: input byte.
- `ram_en` in 1: byte valid this cycle.
- `frame_release` in 1: one-cycle pulse from the core, frees bank `frame_bank`.
- `w_we` out 1: weight RAM write strobe.
- `w_addr` out 6: weight RAM address, 0..53.
- `w_data` out 8: weight RAM data.
- `d_we` out 1: data buffer write strobe.
- `d_bank` out 1: data buffer bank being written.
- `d_addr` out 6: data buffer address, 0..63.
- `d_data` out 8: data buffer data.
- `weights_ok` out 1: a full weight set is resident.
- `frame_avail` out 1: bank `frame_bank` holds a complete frame and `weights_ok` is high.
- `frame_bank` out 1: bank the core must read next.
- `frame_cnt` out 8: completed frames, wraps at 255 to 0.
- `overflow` out 1: sticky; set when a data byte is dropped.

## Operation
- Internal state:
  - `w_cnt` (0..53), `d_cnt` (0..63).
  - `wr_bank`, `rd_bank`.
  - `full[1:0]`: one flag per bank.
- Accepted weight byte (`ram_en`=1, `mode`=1):
  - Write to `w_addr`=`w_cnt`.
  - If `w_cnt`==0, clear `weights_ok`.
  - If `w_cnt`==53, wrap `w_cnt` to 0 and set `weights_ok`; otherwise increment.
  - A partial data frame is discarded: `d_cnt` returns to 0 and the bank is not marked full.
- Data byte (`ram_en`=1, `mode`=0):
  - If `full[wr_bank]`=1, drop the byte, set `overflow`, and leave `d_cnt` unchanged.
  - Otherwise write it to `d_bank`=`wr_bank`, `d_addr`=`d_cnt`.
  - On `d_cnt`==63: set `full[wr_bank]`, toggle `wr_bank`, set `d_cnt` to 0, increment `frame_cnt`.
  - A partial weight load is not affected by data bytes.
- Data frames are accepted even when `weights_ok`=0; `frame_avail` stays low until weights are loaded.
- `frame_release`:
  - Clears `full[rd_bank]` and toggles `rd_bank`.
  - Ignored when `full[rd_bank]`=0.
- Full check:
  - Uses the registered `full` value.
  - A release and a byte aimed at the same full bank in the same cycle: the byte is dropped and `overflow` is set.
  - A release and a fill of different banks in the same cycle are both honoured.
- `frame_bank` = `rd_bank`.
- `ram_en`=0 holds all counters.

## Timing
- Reset values:
  - All outputs 0: `w_we`, `d_we`, the addresses, data, `d_bank`, `weights_ok`, `frame_avail`, `frame_bank`, `frame_cnt`, `overflow`.
  - All counters 0, `full`=00, `wr_bank` and `rd_bank` 0.
- Reset asserted mid-frame or mid-weight-load aborts immediately; no write strobe is issued in the reset cycle.
- Write-port latency: a byte sampled at edge N drives `w_*`/`d_*` with the strobe high during cycle N→N+1, one cycle later. Strobes are single-cycle per byte.
- `full`, `frame_cnt` and `weights_ok` update at the same edge that launches the final write strobe.
- `frame_avail`:
  - Registered; it rises one cycle after the last `d_we` of the frame, so the RAM write has landed before it is seen.
  - Falls the cycle after `frame_release` unless the other bank is already full.
- Throughput: one byte per cycle sustained. With prompt releases there are no bubbles between frames.

## Test plan
- Weight load, 54 consecutive bytes with values 0..53:
  - `w_we` on 54 cycles; `w_addr`=`w_data`=0..53.
  - `weights_ok` rises with the final write and stays high.
- Weights loaded, then 64 data bytes:
  - `d_bank`=0, `d_addr` 0..63.
  - `frame_avail`=1 with `frame_bank`=0 one cycle after the last `d_we`; `frame_cnt`=1.
- Three back-to-back frames with no release:
  - Banks 0 and 1 fill; `frame_cnt`=2.
  - All 64 bytes of frame 3 are dropped (no `d_we`); `overflow`=1.
- Same stream, with `frame_release` pulsed one cycle after each `frame_avail` rise:
  - 100 frames are written with alternating `d_bank`; `frame_cnt`=100; `overflow`=0.
- 30 data bytes, then a weight byte:
  - `d_cnt` resets; the next data byte goes to `d_addr`=0 of the same bank; no `frame_avail`.
- `rst` pulsed at data byte 40:
  - All outputs return to 0 asynchronously.
  - The next frame starts at bank 0, address 0; `weights_ok`=0 until a reload.
